// File: rtl/fifo_burst_drain_if.sv
// rtl/fifo_burst_drain_if.sv - FIFO pop port plus registered burst output stream.
interface fifo_burst_drain_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  fifo_full_i;
  logic [ADDR_DEPTH-1:0] fifo_usage_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_pop_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  last_o;

  modport master (
    input  fifo_full_i, fifo_usage_i, fifo_data_i, ready_i,
    output fifo_pop_o, valid_o, data_o, last_o
  );

  modport slave (
    output fifo_full_i, fifo_usage_i, fifo_data_i, ready_i,
    input  fifo_pop_o, valid_o, data_o, last_o
  );
endinterface

// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - burst-gathering FIFO drain; FIFO_BURST_DRAIN_TIMEOUT_EN adds the short-burst timeout.
module fifo_burst_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  fifo_burst_drain_if.master bus,
  output logic               busy_o
);
  localparam int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW         = ADDR_DEPTH + 1;
  localparam logic [CW-1:0] BLEN_MAX = CW'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > DEPTH || TIMEOUT < 1) begin : g_bad_param
    $error("fifo_burst_drain: illegal parameter combination");
  end

`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] timer;
`else
  typedef enum logic [1:0] {S_IDLE, S_BURST} state_t;
`endif

  state_t state, state_nxt;

  logic [CW-1:0]         avail;
  logic [CW-1:0]         blen;
  logic [CW-1:0]         npop;
  logic [CW-1:0]         nbeat;
  logic                  valid_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  pop;
  logic                  hs;

  // A full FIFO at power-of-two depth reports usage 0, so the flag takes over.
  assign avail = bus.fifo_full_i ? CW'(DEPTH) : {1'b0, bus.fifo_usage_i};
  assign hs    = valid_q && bus.ready_i;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (avail >= BLEN_MAX)
          state_nxt = S_BURST;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
        else if (avail != '0)
          state_nxt = S_WAIT;
`endif
      end
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
      S_WAIT: begin
        if (avail >= BLEN_MAX || timer == TW'(TIMEOUT - 1))
          state_nxt = S_BURST;
      end
`endif
      S_BURST: begin
        pop = (npop < blen) && (!valid_q || bus.ready_i);
        if (hs && (nbeat + CW'(1) == blen))
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush_i) begin
      state_nxt = S_IDLE;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      blen    <= '0;
      npop    <= '0;
      nbeat   <= '0;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
      timer   <= '0;
`endif
    end else if (flush_i) begin
      state   <= S_IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      npop    <= '0;
      nbeat   <= '0;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
      timer   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state != S_BURST && state_nxt == S_BURST) begin
        blen  <= (avail < BLEN_MAX) ? avail : BLEN_MAX;
        npop  <= '0;
        nbeat <= '0;
      end else if (state == S_BURST) begin
        if (pop) begin
          npop    <= npop + CW'(1);
          data_q  <= bus.fifo_data_i;
          valid_q <= 1'b1;
          last_q  <= (npop + CW'(1) == blen);
        end else if (hs) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
        if (hs)
          nbeat <= nbeat + CW'(1);
      end
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
      if (state != S_WAIT && state_nxt == S_WAIT)
        timer <= '0;
      else if (state == S_WAIT)
        timer <= timer + TW'(1);
`endif
    end
  end

  assign bus.fifo_pop_o = pop;
  assign bus.valid_o    = valid_q;
  assign bus.data_o     = data_q;
  assign bus.last_o     = last_q;
  assign busy_o         = (state != S_IDLE) || valid_q;
endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb/tb_fifo_burst_drain.sv - scoreboard bench for fifo_burst_drain against a behavioural FIFO.
module tb_fifo_burst_drain;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int BL    = 4;
  localparam int TO    = 16;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  logic rdy   = 1'b0;
  logic busy;

  logic [2:0]    f_usage = '0;
  logic          f_full  = 1'b0;
  logic [DW-1:0] f_data  = '0;

  fifo_burst_drain_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  assign bus.fifo_usage_i = f_usage;
  assign bus.fifo_full_i  = f_full;
  assign bus.fifo_data_i  = f_data;
  assign bus.ready_i      = rdy;

  fifo_burst_drain #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nbeats = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] pend_q[$];
  logic [DW:0]   exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // FIFO model: registered flags, head visible before pop, flushed with the block.
  always @(posedge clk) begin
    if (flush)
      fq.delete();
    else if (bus.fifo_pop_o) begin
      if (fq.size() == 0) chk("pop_empty", 1, 0);
      else void'(fq.pop_front());
    end
    while (pend_q.size() > 0) fq.push_back(pend_q.pop_front());
    f_usage <= 3'(fq.size());
    f_full  <= (fq.size() == DEPTH);
    f_data  <= (fq.size() > 0) ? fq[0] : '0;
  end

  always @(negedge clk) begin
    if (!rst && bus.valid_o && bus.ready_i) begin
      logic [DW:0] e;
      nbeats++;
      if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("beat_data", bus.data_o, e[DW-1:0]);
        chk("beat_last", bus.last_o, e[DW]);
      end
    end
  end

  task automatic push(input logic [DW-1:0] base, input int n, input int last_at, input int n_exp);
    for (int i = 0; i < n; i++) begin
      pend_q.push_back(base + DW'(i));
      if (i < n_exp) exp_q.push_back({(i == last_at), base + DW'(i)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_cnt;
    bit prev_stall;
    logic [DW-1:0] prev_data;
    int exp_beats;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_last", bus.last_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pop", bus.fifo_pop_o, 0);
    rst = 1'b0;
    tick(); tick();

    // full burst of 4, ready held high
    rdy = 1'b1;
    push(32'h1000, 4, 3, 4);
    for (int k = 0; k <= 6; k++) begin
      tick();
      @(negedge clk);
      chk("t1_pop", bus.fifo_pop_o, (k >= 1 && k <= 4));
      chk("t1_valid", bus.valid_o, (k >= 2 && k <= 5));
      chk("t1_last", bus.last_o, (k == 5));
    end
    chk("t1_busy", busy, 0);

    // two entries only: timeout short burst, or no output at all
    tick();
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
    push(32'h2000, 2, 1, 2);
`else
    push(32'h2000, 2, -1, 2);
`endif
    for (int k = 0; k <= 21; k++) begin
      tick();
      @(negedge clk);
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
      chk("t2_valid", bus.valid_o, (k == 18 || k == 19));
      chk("t2_last", bus.last_o, (k == 19));
      if (k == 10) chk("t2_busy_wait", busy, 1);
`else
      chk("t2_valid", bus.valid_o, 0);
      if (k == 10) chk("t2_busy_idle", busy, 0);
`endif
    end
`ifndef FIFO_BURST_DRAIN_TIMEOUT_EN
    tick();
    push(32'h2002, 2, 1, 2);
    repeat (10) tick();
`endif

    // backpressure: ready high one cycle in three
    tick();
    push(32'h3000, 4, 3, 4);
    hs_cnt = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c <= 19; c++) begin
      tick();
      rdy = (c % 3 == 0);
      @(negedge clk);
      if (bus.valid_o && bus.ready_i) hs_cnt++;
      if (bus.valid_o && !bus.ready_i) begin
        chk("t3_nopop", bus.fifo_pop_o, 0);
        if (prev_stall) chk("t3_hold", bus.data_o, prev_data);
        prev_stall = 1'b1;
        prev_data = bus.data_o;
      end else
        prev_stall = 1'b0;
    end
    chk("t3_handshakes", hs_cnt, 4);
    chk("t3_busy", busy, 0);

    // full FIFO: usage wraps to 0, two bursts back to back
    tick();
    rdy = 1'b1;
    push(32'h4000, 4, 3, 4);
    push(32'h4004, 4, 3, 4);
    for (int k = 0; k <= 12; k++) begin
      tick();
      @(negedge clk);
      chk("t4_valid", bus.valid_o, ((k >= 2 && k <= 5) || (k >= 8 && k <= 11)));
      chk("t4_last", bus.last_o, (k == 5 || k == 11));
    end

    // flush while the third beat is presented
    tick();
    push(32'h5000, 4, -1, 2);
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 4) begin flush = 1'b1; rdy = 1'b0; end
      if (k == 5) begin flush = 1'b0; rdy = 1'b1; end
      @(negedge clk);
      if (k == 3) chk("t5_valid_pre", bus.valid_o, 1);
      if (k == 4) chk("t5_pop_flush", bus.fifo_pop_o, 0);
      if (k >= 5) begin
        chk("t5_valid", bus.valid_o, 0);
        chk("t5_busy", busy, 0);
        chk("t5_pop", bus.fifo_pop_o, 0);
        chk("t5_last", bus.last_o, 0);
      end
    end

    // async reset while a stalled beat is held
    tick();
    rdy = 1'b0;
    push(32'h6000, 4, -1, 0);
    for (int k = 0; k <= 3; k++) begin
      tick();
      @(negedge clk);
    end
    chk("t6_valid_pre", bus.valid_o, 1);
    chk("t6_data_pre", bus.data_o, 32'h6000);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", bus.valid_o, 0);
    chk("t6_last", bus.last_o, 0);
    chk("t6_data", bus.data_o, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pop", bus.fifo_pop_o, 0);
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    for (int i = 1; i <= 3; i++) exp_q.push_back({1'b0, 32'h6000 + DW'(i)});
    push(32'h6004, 1, 0, 1);
    repeat (12) tick();

    repeat (3) tick();
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
    exp_beats = 24;
`else
    exp_beats = 26;
`endif
    chk("sb_empty", exp_q.size(), 0);
    chk("beats_total", nbeats, exp_beats);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
